// File: rtl/frame_pkg.sv
// Shared constants for the VGA frame capture block:
// default geometry, FSM encoding and decimation codes.
package frame_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int CAP_W_DEF    = 160;
   localparam int CAP_H_DEF    = 120;

   typedef logic [9:0] coord_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_VS = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [1:0] DEC_1   = 2'd0;
   localparam logic [1:0] DEC_2   = 2'd1;
   localparam logic [1:0] DEC_4   = 2'd2;
   localparam logic [1:0] DEC_1_B = 2'd3;

   // log2 of the decimation factor
   function automatic logic [1:0] dec_shift(input logic [1:0] sel);
      logic [1:0] sh;
      sh = 2'd0;
      unique case (sel)
         DEC_1:   sh = 2'd0;
         DEC_2:   sh = 2'd1;
         DEC_4:   sh = 2'd2;
         DEC_1_B: sh = 2'd0;
         default: sh = 2'd0;
      endcase
      return sh;
   endfunction

   // low-bit mask for the "offset is a multiple of N" test
   function automatic logic [1:0] dec_mask(input logic [1:0] sh);
      logic [1:0] m;
      m = 2'b00;
      unique case (sh)
         2'd1:    m = 2'b01;
         2'd2:    m = 2'b11;
         default: m = 2'b00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers an active-low sync on pixel strobes and flags
// the 1->0 transition against the previous sample.
module sync_edge_det (
   input  logic clock,
   input  logic vga_reset,
   input  logic pix_en,
   input  logic sync_in,
   output logic fall
);

   logic sync_q;

   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         sync_q <= 1'b1;
      end else if (pix_en) begin
         sync_q <= sync_in;
      end
   end

   assign fall = pix_en & sync_q & ~sync_in;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one decimated window of a VGA-timed pixel stream
// and writes it linearly into the framebuffer write port.
module vga_frame_capture
   import frame_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int CAP_W    = CAP_W_DEF,
   parameter int CAP_H    = CAP_H_DEF,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 8
) (
   input  logic              clock,
   input  logic              vga_reset,
   input  logic              pix_en,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              blank_in,
   input  logic [DATA_W-1:0] color_in,
   input  logic              start,
   input  logic [1:0]        dec_sel,
   input  logic [9:0]        x_off,
   input  logic [9:0]        y_off,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   localparam int TOTAL = CAP_W * CAP_H;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(CAP_W);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam coord_t           SAT_MAX  = 10'h3ff;
   localparam coord_t           H_LIM    = 10'(H_ACTIVE);
   localparam coord_t           V_LIM    = 10'(V_ACTIVE);
   localparam logic [11:0]      CAP_W12  = 12'(CAP_W);
   localparam logic [11:0]      CAP_H12  = 12'(CAP_H);

   logic              hs_fall;
   logic              vs_fall;
   coord_t            sx;
   coord_t            sy;
   logic              line_act;
   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [1:0]        dec_q;
   coord_t            xo_q;
   coord_t            yo_q;
   logic [ADDR_W-1:0] col;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] cnt;
   logic              row_kept;

   logic [1:0]        sh;
   logic [1:0]        mask;
   logic [10:0]       rel_x;
   logic [10:0]       rel_y;
   logic [11:0]       span_x;
   logic [11:0]       span_y;
   logic              in_x;
   logic              in_y;
   logic              pix_ok;
   logic              capturing;
   logic              keep;
   logic              last;
   logic              start_acc;

   sync_edge_det u_hs (
      .clock     (clock),
      .vga_reset (vga_reset),
      .pix_en    (pix_en),
      .sync_in   (hsync_in),
      .fall      (hs_fall)
   );

   sync_edge_det u_vs (
      .clock     (clock),
      .vga_reset (vga_reset),
      .pix_en    (pix_en),
      .sync_in   (vsync_in),
      .fall      (vs_fall)
   );

   // Stream position; vsync wins over hsync on the same strobe
   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         sx       <= '0;
         sy       <= '0;
         line_act <= 1'b0;
      end else if (pix_en) begin
         if (vs_fall) begin
            sx       <= '0;
            sy       <= '0;
            line_act <= 1'b0;
         end else if (hs_fall) begin
            sx       <= '0;
            line_act <= 1'b0;
            if (line_act && sy != SAT_MAX) begin
               sy <= sy + 10'd1;
            end
         end else if (blank_in) begin
            line_act <= 1'b1;
            if (sx != SAT_MAX) begin
               sx <= sx + 10'd1;
            end
         end
      end
   end

   assign start_acc = start & (state == ST_IDLE);

   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         dec_q <= DEC_1;
         xo_q  <= '0;
         yo_q  <= '0;
      end else if (start_acc) begin
         dec_q <= dec_sel;
         xo_q  <= x_off;
         yo_q  <= y_off;
      end
   end

   // Window compare: offsets from the window origin, span N*CAP
   assign sh        = dec_shift(dec_q);
   assign mask      = dec_mask(sh);
   assign rel_x     = {1'b0, sx} - {1'b0, xo_q};
   assign rel_y     = {1'b0, sy} - {1'b0, yo_q};
   assign span_x    = CAP_W12 << sh;
   assign span_y    = CAP_H12 << sh;
   assign in_x      = ~rel_x[10] & ({2'b00, rel_x[9:0]} < span_x);
   assign in_y      = ~rel_y[10] & ({2'b00, rel_y[9:0]} < span_y);
   assign pix_ok    = pix_en & blank_in;
   assign capturing = (state == ST_CAPTURE);
   assign keep      = capturing & pix_ok & in_x & in_y
                    & ((rel_x[1:0] & mask) == 2'b00)
                    & ((rel_y[1:0] & mask) == 2'b00);
   assign last      = keep & (cnt == LAST_IDX);

   // Address generator: row_base steps by CAP_W after each kept row
   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         col      <= '0;
         row_base <= '0;
         row_kept <= 1'b0;
      end else if (start_acc || vs_fall) begin
         col      <= '0;
         row_base <= '0;
         row_kept <= 1'b0;
      end else if (hs_fall) begin
         col      <= '0;
         row_kept <= 1'b0;
         if (row_kept) begin
            row_base <= row_base + ROW_STEP;
         end
      end else if (keep) begin
         col      <= col + ONE_A;
         row_kept <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         cnt <= '0;
      end else if (start_acc || vs_fall) begin
         cnt <= '0;
      end else if (keep) begin
         cnt <= cnt + ONE_A;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:    if (start)   state_nx = ST_WAIT_VS;
         ST_WAIT_VS: if (vs_fall) state_nx = ST_CAPTURE;
         ST_CAPTURE: if (last || vs_fall) state_nx = ST_DONE;
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         wr_en <= keep;
         busy  <= (state_nx == ST_WAIT_VS) | (state_nx == ST_CAPTURE);
         done  <= (state_nx == ST_DONE);
         if (keep) begin
            wr_addr <= row_base + col;
            wr_data <= color_in;
         end
      end
   end

   // Overlong line/frame, or a frame that ended before the image filled
   always_ff @(posedge clock or negedge vga_reset) begin
      if (!vga_reset) begin
         frame_err <= 1'b0;
      end else if (start_acc) begin
         frame_err <= 1'b0;
      end else if (capturing) begin
         if (pix_ok && (sx >= H_LIM || sy >= V_LIM)) begin
            frame_err <= 1'b1;
         end
         if (vs_fall && !last) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule
